// File: rtl/cacc_grp_sched_pkg.sv
// Shared definitions for the CACC ping-pong register-group scheduler:
// group count, status encoding, FSM state codes and small decode helpers.
package cacc_grp_sched_pkg;

   localparam int NUM_GRP = 2;

   // Per-group status as read back by the register block.
   localparam logic [1:0] STAT_IDLE    = 2'd0;
   localparam logic [1:0] STAT_RUNNING = 2'd1;
   localparam logic [1:0] STAT_PENDING = 2'd2;

   // Scheduler FSM state codes.
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LAUNCH = 2'd1;
   localparam logic [1:0] ST_BUSY   = 2'd2;

   // One-hot vector selecting a single group.
   function automatic logic [NUM_GRP-1:0] grp_onehot(input logic grp);
      return grp ? 2'b10 : 2'b01;
   endfunction

   // A running group reports RUNNING even while its op_en is still set.
   function automatic logic [1:0] grp_status(input logic running, input logic armed);
      if (running)
         return STAT_RUNNING;
      else if (armed)
         return STAT_PENDING;
      else
         return STAT_IDLE;
   endfunction

endpackage

// File: rtl/cacc_grp_sched_if.sv
// Software/datapath-facing signal bundle of the group scheduler.
// slave: the scheduler itself; master: the register block / datapath side.
interface cacc_grp_sched_if;
   import cacc_grp_sched_pkg::*;

   logic               op_en_wr;
   logic               op_en_grp;
   logic               dp_done;
   logic               consumer;
   logic [1:0]         status_0;
   logic [1:0]         status_1;
   logic [NUM_GRP-1:0] op_en;
   logic               dp_start;
   logic               dp_grp;
   logic [NUM_GRP-1:0] done_pulse;
   logic               wr_err;
   logic               timeout;

   modport slave (
      input  op_en_wr, op_en_grp, dp_done,
      output consumer, status_0, status_1, op_en, dp_start, dp_grp,
             done_pulse, wr_err, timeout
   );

   modport master (
      output op_en_wr, op_en_grp, dp_done,
      input  consumer, status_0, status_1, op_en, dp_start, dp_grp,
             done_pulse, wr_err, timeout
   );

endinterface

// File: rtl/cacc_grp_wdog.sv
// Busy-cycle watchdog: saturating counter cleared on launch, counting in
// BUSY, flagging one cycle when the threshold is reached. Never aborts a run.
module cacc_grp_wdog #(
   parameter int unsigned TIMEOUT_CYC = 0,
   parameter int          TO_W        = 24
) (
   input  logic nvdla_core_clk,
   input  logic nvdla_core_rstn,
   input  logic launch,
   input  logic busy,
   output logic timeout
);

   localparam bit             WDOG_EN = (TIMEOUT_CYC != 0);
   localparam logic [TO_W-1:0] THRESH = WDOG_EN ? TO_W'(TIMEOUT_CYC - 1) : '0;

   logic [TO_W-1:0] cnt;

   // Clear at launch, count busy cycles, hold at the all-ones ceiling.
   always_ff @(posedge nvdla_core_clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (!nvdla_core_rstn)
         cnt <= '0;
      else if (launch)
         cnt <= '0;
      else if (busy && (cnt != '1))
         cnt <= cnt + 1'b1;
   end

   // The count passes THRESH exactly once per run, so this is a single pulse.
   assign timeout = WDOG_EN && busy && (cnt == THRESH);

endmodule

// File: rtl/cacc_grp_sched.sv
// Ping-pong register-group scheduler: launches armed groups on the CACC
// datapath in strict alternation and tracks per-group status.
module cacc_grp_sched
   import cacc_grp_sched_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 0,
   parameter int          TO_W        = 24
) (
   input  logic               nvdla_core_clk,
   input  logic               nvdla_core_rstn,
   cacc_grp_sched_if.slave    sch
);

   logic [1:0]         state;
   logic [1:0]         state_nxt;
   logic               consumer;
   logic [NUM_GRP-1:0] op_en;
   logic [NUM_GRP-1:0] op_en_nxt;
   logic [NUM_GRP-1:0] done_pulse;
   logic               wr_err;
   logic               running;
   logic               cmpl;
   logic               wr_hit_cmpl;
   logic               wr_set;
   logic               wr_dup;

   assign running = (state != ST_IDLE);
   assign cmpl    = (state == ST_BUSY) && sch.dp_done;

   // A write landing on the group being retired in the same cycle is a
   // re-arm, not a duplicate: the clear takes the slot, the set follows.
   assign wr_hit_cmpl = cmpl && (sch.op_en_grp == consumer);
   assign wr_set      = sch.op_en_wr && (!op_en[sch.op_en_grp] || wr_hit_cmpl);
   assign wr_dup      = sch.op_en_wr &&  op_en[sch.op_en_grp] && !wr_hit_cmpl;

   // Next-state and next-op_en decode.
   always_comb begin
      // NOTE: defaults first so every path assigns every output; a missing
      // branch would otherwise infer a latch.
      state_nxt = state;
      op_en_nxt = op_en;
      case (state)
         ST_IDLE:   if (op_en[consumer]) state_nxt = ST_LAUNCH;
         ST_LAUNCH: state_nxt = ST_BUSY;
         ST_BUSY:   if (sch.dp_done) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
      if (cmpl)
         op_en_nxt[consumer] = 1'b0;
      if (wr_set)
         op_en_nxt[sch.op_en_grp] = 1'b1;
   end

   // Scheduler registers; completion retires the group and hands over.
   always_ff @(posedge nvdla_core_clk) begin
      if (!nvdla_core_rstn) begin
         state      <= ST_IDLE;
         consumer   <= 1'b0;
         op_en      <= '0;
         done_pulse <= '0;
         wr_err     <= 1'b0;
      end else begin
         state      <= state_nxt;
         op_en      <= op_en_nxt;
         consumer   <= consumer ^ cmpl;
         done_pulse <= cmpl ? grp_onehot(consumer) : '0;
         wr_err     <= wr_dup;
      end
   end

   cacc_grp_wdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .TO_W        (TO_W)
   ) u_wdog (
      .nvdla_core_clk  (nvdla_core_clk),
      .nvdla_core_rstn (nvdla_core_rstn),
      .launch          (state == ST_LAUNCH),
      .busy            (state == ST_BUSY),
      .timeout         (sch.timeout)
   );

   assign sch.consumer   = consumer;
   assign sch.op_en      = op_en;
   assign sch.dp_start   = (state == ST_LAUNCH);
   assign sch.dp_grp     = consumer;
   assign sch.done_pulse = done_pulse;
   assign sch.wr_err     = wr_err;
   assign sch.status_0   = grp_status(running && (consumer == 1'b0), op_en[0]);
   assign sch.status_1   = grp_status(running && (consumer == 1'b1), op_en[1]);

endmodule

// File: tb/tb_cacc_grp_sched.sv
// Directed self-checking bench for cacc_grp_sched (watchdog threshold 8).
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_cacc_grp_sched;

   logic nvdla_core_clk = 1'b0;
   logic nvdla_core_rstn;
   int   vectors    = 0;
   int   miscompares = 0;

   cacc_grp_sched_if sch_if ();

   cacc_grp_sched #(
      .TIMEOUT_CYC (8),
      .TO_W        (24)
   ) dut (
      .nvdla_core_clk  (nvdla_core_clk),
      .nvdla_core_rstn (nvdla_core_rstn),
      .sch             (sch_if)
   );

   always #5 nvdla_core_clk = ~nvdla_core_clk;

   task automatic tick();
      @(posedge nvdla_core_clk);
      #1;
   endtask

   task automatic chk(input string tag, input int observed, input int expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".consumer"},   int'(sch_if.consumer),   0);
      chk({tag, ".op_en"},      int'(sch_if.op_en),      0);
      chk({tag, ".status_0"},   int'(sch_if.status_0),   0);
      chk({tag, ".status_1"},   int'(sch_if.status_1),   0);
      chk({tag, ".dp_start"},   int'(sch_if.dp_start),   0);
      chk({tag, ".done_pulse"}, int'(sch_if.done_pulse), 0);
      chk({tag, ".wr_err"},     int'(sch_if.wr_err),     0);
      chk({tag, ".timeout"},    int'(sch_if.timeout),    0);
   endtask

   task automatic do_reset();
      nvdla_core_rstn  = 1'b0;
      sch_if.op_en_wr  = 1'b0;
      sch_if.op_en_grp = 1'b0;
      sch_if.dp_done   = 1'b0;
      tick();
      tick();
      nvdla_core_rstn  = 1'b1;
   endtask

   task automatic write_grp(input logic grp);
      sch_if.op_en_wr  = 1'b1;
      sch_if.op_en_grp = grp;
      tick();
      sch_if.op_en_wr  = 1'b0;
   endtask

   initial begin
      // Reset values
      do_reset();
      chk_reset_vals("rst");

      // Single group 0 run: write at t, PENDING t+1, LAUNCH t+2, BUSY t+3
      write_grp(1'b0);
      chk("t1.status_0", int'(sch_if.status_0), 2);
      chk("t1.op_en",    int'(sch_if.op_en),    1);
      chk("t1.start0",   int'(sch_if.dp_start), 0);
      tick();
      chk("t2.dp_start", int'(sch_if.dp_start), 1);
      chk("t2.dp_grp",   int'(sch_if.dp_grp),   0);
      chk("t2.status_0", int'(sch_if.status_0), 1);
      tick();
      chk("t3.dp_start", int'(sch_if.dp_start), 0);
      chk("t3.status_0", int'(sch_if.status_0), 1);
      sch_if.dp_done = 1'b1;
      tick();
      sch_if.dp_done = 1'b0;
      chk("d1.done",     int'(sch_if.done_pulse), 1);
      chk("d1.consumer", int'(sch_if.consumer),   1);
      chk("d1.status_0", int'(sch_if.status_0),   0);
      chk("d1.op_en",    int'(sch_if.op_en),      0);
      tick();
      chk("d2.done",     int'(sch_if.done_pulse), 0);
      chk("d2.dp_start", int'(sch_if.dp_start),   0);

      // Arm group 1 while group 0 is busy; hand-over two cycles after done
      do_reset();
      write_grp(1'b0);
      tick();
      tick();
      write_grp(1'b1);
      chk("pp.status_1a", int'(sch_if.status_1), 2);
      chk("pp.status_0a", int'(sch_if.status_0), 1);
      chk("pp.op_en",     int'(sch_if.op_en),    3);
      chk("pp.wr_err",    int'(sch_if.wr_err),   0);
      tick();
      chk("pp.status_1b", int'(sch_if.status_1), 2);
      sch_if.dp_done = 1'b1;
      tick();
      sch_if.dp_done = 1'b0;
      chk("pp.d1.done",     int'(sch_if.done_pulse), 1);
      chk("pp.d1.consumer", int'(sch_if.consumer),   1);
      chk("pp.d1.status_1", int'(sch_if.status_1),   2);
      chk("pp.d1.dp_start", int'(sch_if.dp_start),   0);
      chk("pp.d1.op_en",    int'(sch_if.op_en),      2);
      tick();
      chk("pp.d2.dp_start", int'(sch_if.dp_start), 1);
      chk("pp.d2.dp_grp",   int'(sch_if.dp_grp),   1);
      chk("pp.d2.status_1", int'(sch_if.status_1), 1);
      chk("pp.d2.status_0", int'(sch_if.status_0), 0);
      tick();
      sch_if.dp_done = 1'b1;
      tick();
      sch_if.dp_done = 1'b0;
      chk("pp.g1.done",     int'(sch_if.done_pulse), 2);
      chk("pp.g1.consumer", int'(sch_if.consumer),   0);
      chk("pp.g1.op_en",    int'(sch_if.op_en),      0);

      // Group 1 armed alone must not launch: consumer is still group 0
      do_reset();
      write_grp(1'b1);
      for (int i = 0; i < 20; i++) begin
         chk("g1only.dp_start", int'(sch_if.dp_start), 0);
         chk("g1only.status_1", int'(sch_if.status_1), 2);
         tick();
      end
      chk("g1only.consumer", int'(sch_if.consumer), 0);

      // Duplicate write to group 0 flags wr_err once, op_en unchanged
      do_reset();
      write_grp(1'b0);
      chk("dup.op_en1",  int'(sch_if.op_en),  1);
      chk("dup.wr_err1", int'(sch_if.wr_err), 0);
      write_grp(1'b0);
      chk("dup.wr_err2", int'(sch_if.wr_err),   1);
      chk("dup.op_en2",  int'(sch_if.op_en),    1);
      chk("dup.launch",  int'(sch_if.dp_start), 1);
      tick();
      chk("dup.wr_err3", int'(sch_if.wr_err), 0);
      chk("dup.op_en3",  int'(sch_if.op_en),  1);

      // Completion and re-arm of group 0 in the same cycle (group 0 BUSY)
      sch_if.dp_done   = 1'b1;
      sch_if.op_en_wr  = 1'b1;
      sch_if.op_en_grp = 1'b0;
      tick();
      sch_if.dp_done   = 1'b0;
      sch_if.op_en_wr  = 1'b0;
      chk("rearm.consumer", int'(sch_if.consumer),   1);
      chk("rearm.op_en",    int'(sch_if.op_en),      1);
      chk("rearm.status_0", int'(sch_if.status_0),   2);
      chk("rearm.done",     int'(sch_if.done_pulse), 1);
      tick();
      chk("rearm.wr_err",   int'(sch_if.wr_err),   0);
      chk("rearm.dp_start", int'(sch_if.dp_start), 0);

      // Watchdog: threshold 8, dp_done withheld; pulse in BUSY cycle 8 only
      do_reset();
      write_grp(1'b0);
      tick();
      chk("wd.launch", int'(sch_if.dp_start), 1);
      chk("wd.to_launch", int'(sch_if.timeout), 0);
      for (int k = 1; k <= 12; k++) begin
         tick();
         chk($sformatf("wd.busy%0d", k), int'(sch_if.timeout), int'(k == 8));
      end
      chk("wd.status_0", int'(sch_if.status_0), 1);
      sch_if.dp_done = 1'b1;
      tick();
      sch_if.dp_done = 1'b0;
      chk("wd.done", int'(sch_if.done_pulse), 1);

      // Reset during BUSY, coincident with dp_done: no done_pulse
      do_reset();
      write_grp(1'b0);
      tick();
      tick();
      write_grp(1'b1);
      chk("mid.status_0", int'(sch_if.status_0), 1);
      nvdla_core_rstn = 1'b0;
      sch_if.dp_done  = 1'b1;
      tick();
      sch_if.dp_done  = 1'b0;
      chk_reset_vals("mid");
      nvdla_core_rstn = 1'b1;
      tick();
      chk("mid.after.done",  int'(sch_if.done_pulse), 0);
      chk("mid.after.start", int'(sch_if.dp_start),   0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
